prf_free_list: RTL and testbench

//  Physical-register allocator for the 256-entry PRF; sits between rename and the PRF.

---
 rtl/prf_free_list.sv | 177 +++++++++++++++++
 tb/tb_prf_free_list.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prf_free_list.sv
// -----------------------------------------------------------------------------
// prf_free_list
//
// Physical-register allocator between rename and the physical register file.
// Free physical tags are kept in a circular FIFO. Rename pops one tag per
// cycle from it, and commit pushes released tags back. A free-bitmap records
// which tags are currently free, so a release of a tag that is already free
// (a double free) is rejected and flagged. Every grant is followed one cycle
// later by an invalidate pulse, which lets the PRF clear that entry's Valid bit.
//
// At reset, architectural registers P0..P(NUM_AREGS-1) are treated as mapped.
// The FIFO holds tags NUM_AREGS..NUM_PREGS-1 in order. Tag 0 is never
// allocated or freed.
//
// Ports
//   clk_i              clock; all state updates on the rising edge
//   rst_i              asynchronous active-high reset
//   alloc_req_i        rename wants one physical tag this cycle
//   alloc_gnt_o        combinational grant: alloc_req_i and at least one tag free
//   alloc_tag_o        combinational tag at the FIFO head (meaningful when not empty)
//   free_valid_i       commit releases free_tag_i this cycle
//   free_tag_i         tag being released
//   free_count_o       registered number of free tags, 0..D
//   empty_o            no free tags
//   full_o             all D tags are free
//   prf_inval_valid_o  one-cycle pulse in the cycle after each grant
//   prf_inval_addr_o   tag granted in the previous cycle
//   err_free_o         sticky illegal-free flag; only reset clears it
// -----------------------------------------------------------------------------
module prf_free_list #(
    parameter int NUM_PREGS = 256,
    parameter int NUM_AREGS = 32,
    parameter int TAG_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_req_i,
    output logic             alloc_gnt_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic             free_valid_i,
    input  logic [TAG_W-1:0] free_tag_i,
    output logic [TAG_W:0]   free_count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             prf_inval_valid_o,
    output logic [TAG_W-1:0] prf_inval_addr_o,
    output logic             err_free_o
);

    localparam int D     = NUM_PREGS - NUM_AREGS;
    localparam int PTR_W = (D > 1) ? $clog2(D) : 1;
    localparam int CNT_W = TAG_W + 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(D - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(D);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             inval_valid_q;
    logic [TAG_W-1:0] inval_addr_q;
    logic             err_q, err_d;

    logic [TAG_W-1:0]     fifo_rd [D];
    logic [NUM_PREGS-1:0] bitmap;

    logic free_live;
    logic free_ok;
    logic free_bad;

    // Pointer advance with an explicit wrap, because D need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Grant path: same-cycle handshake, with no bypass of a same-cycle free
    // ------------------------------------------------------------------
    assign alloc_gnt_o = alloc_req_i && (count_q != '0);
    assign alloc_tag_o = fifo_rd[head_q];

    // ------------------------------------------------------------------
    // Free legality is judged on pre-edge state only. A free of the tag
    // being granted in the same cycle still sees its bitmap bit set, so it
    // falls out as a double free without any extra compare.
    // ------------------------------------------------------------------
    assign free_live = free_valid_i && (free_tag_i != '0);
    assign free_ok   = free_live && !bitmap[free_tag_i] && (count_q != CNT_FULL);
    assign free_bad  = free_live && (bitmap[free_tag_i] || (count_q == CNT_FULL));

    // ------------------------------------------------------------------
    // FIFO storage. Each slot has its own reset value, so these are plain
    // registers rather than a RAM.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < D; gi++) begin : g_slot
        logic [TAG_W-1:0] slot_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                slot_q <= TAG_W'(NUM_AREGS + gi);
            end else if (free_ok && (tail_q == PTR_W'(gi))) begin
                slot_q <= free_tag_i;
            end
        end

        assign fifo_rd[gi] = slot_q;
    end

    // ------------------------------------------------------------------
    // Free-bitmap: 1 means the tag is currently in the FIFO. An accepted
    // free and a grant never target the same tag (see free_ok above), so
    // the order of the two updates does not matter.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PREGS; gi++) begin : g_bit
        logic bit_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                bit_q <= (gi >= NUM_AREGS);
            end else if (free_ok && (free_tag_i == TAG_W'(gi))) begin
                bit_q <= 1'b1;
            end else if (alloc_gnt_o && (alloc_tag_o == TAG_W'(gi))) begin
                bit_q <= 1'b0;
            end
        end

        assign bitmap[gi] = bit_q;
    end

    // ------------------------------------------------------------------
    // Pointer, count and flag next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        err_d   = err_q;
        if (alloc_gnt_o) begin
            head_d = ptr_inc(head_q);
        end
        if (free_ok) begin
            tail_d = ptr_inc(tail_q);
        end
        if (free_bad) begin
            err_d = 1'b1;
        end
        count_d = count_q + CNT_W'(free_ok) - CNT_W'(alloc_gnt_o);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= CNT_FULL;
            inval_valid_q <= 1'b0;
            inval_addr_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            inval_valid_q <= alloc_gnt_o;
            err_q         <= err_d;
            // Address holds its last value between pulses.
            if (alloc_gnt_o) begin
                inval_addr_q <= alloc_tag_o;
            end
        end
    end

    assign free_count_o      = count_q;
    assign empty_o           = (count_q == '0);
    assign full_o            = (count_q == CNT_FULL);
    assign prf_inval_valid_o = inval_valid_q;
    assign prf_inval_addr_o  = inval_addr_q;
    assign err_free_o        = err_q;

endmodule

// File: tb/tb_prf_free_list.sv
module tb_prf_free_list;

    localparam int TAG_W     = 8;
    localparam int NUM_PREGS = 256;
    localparam int NUM_AREGS = 32;
    localparam int D         = NUM_PREGS - NUM_AREGS;

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc_req;
    logic             alloc_gnt;
    logic [TAG_W-1:0] alloc_tag;
    logic             free_valid;
    logic [TAG_W-1:0] free_tag;
    logic [TAG_W:0]   free_count;
    logic             empty;
    logic             full;
    logic             inval_valid;
    logic [TAG_W-1:0] inval_addr;
    logic             err_free;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prf_free_list #(
        .NUM_PREGS (NUM_PREGS),
        .NUM_AREGS (NUM_AREGS),
        .TAG_W     (TAG_W)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .alloc_req_i       (alloc_req),
        .alloc_gnt_o       (alloc_gnt),
        .alloc_tag_o       (alloc_tag),
        .free_valid_i      (free_valid),
        .free_tag_i        (free_tag),
        .free_count_o      (free_count),
        .empty_o           (empty),
        .full_o            (full),
        .prf_inval_valid_o (inval_valid),
        .prf_inval_addr_o  (inval_addr),
        .err_free_o        (err_free)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge, so nothing is sampled near an edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_tag   = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_count"}, 32'(free_count), 32'(D));
        check({pfx, "_full"},  32'(full), 1);
        check({pfx, "_empty"}, 32'(empty), 0);
        check({pfx, "_tag"},   32'(alloc_tag), 32'(NUM_AREGS));
        check({pfx, "_inval"}, 32'(inval_valid), 0);
        check({pfx, "_err"},   32'(err_free), 0);
    endtask

    // One granted allocation, with the invalidate checked one cycle later.
    task automatic alloc_one(input string tag, input int exp_tag);
        alloc_req = 1'b1;
        #1;
        check({tag, "_gnt"}, 32'(alloc_gnt), 1);
        check({tag, "_tag"}, 32'(alloc_tag), 32'(exp_tag));
        tick();
        alloc_req = 1'b0;
        check({tag, "_inv_v"}, 32'(inval_valid), 1);
        check({tag, "_inv_a"}, 32'(inval_addr), 32'(exp_tag));
    endtask

    task automatic free_one(input int t);
        free_valid = 1'b1;
        free_tag   = TAG_W'(t);
        tick();
        free_valid = 1'b0;
        free_tag   = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #12;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1. Reset state
        check_reset_state("t1");

        // 2. Three back-to-back allocations
        for (int k = 0; k < 3; k++) alloc_one($sformatf("t2_a%0d", k), 32 + k);
        check("t2_count", 32'(free_count), 221);
        tick();
        check("t2_inv_off", 32'(inval_valid), 0);

        // 3. Drain the list, then a free while empty is not bypassed
        for (int k = 35; k < 256; k++) alloc_one($sformatf("t3_a%0d", k), k);
        check("t3_empty", 32'(empty), 1);
        check("t3_count0", 32'(free_count), 0);
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_tag   = 8'd5;
        #1;
        check("t3_nobypass_gnt", 32'(alloc_gnt), 0);
        tick();
        idle();
        check("t3_count1", 32'(free_count), 1);
        check("t3_no_inv", 32'(inval_valid), 0);
        check("t3_err", 32'(err_free), 0);
        alloc_one("t3_re5", 5);
        check("t3_empty2", 32'(empty), 1);

        // 4a. Free at full is rejected, including a reset-mapped tag
        do_reset();
        free_one(5);
        check("t4_full5_count", 32'(free_count), 224);
        check("t4_full5_err", 32'(err_free), 1);
        do_reset();
        free_one(40);
        check("t4_full40_count", 32'(free_count), 224);
        check("t4_full40_err", 32'(err_free), 1);

        // 4b. Legal free, then a double free below full
        do_reset();
        alloc_one("t4_a32", 32);
        alloc_one("t4_a33", 33);
        free_one(32);
        check("t4_free32_count", 32'(free_count), 223);
        check("t4_free32_err", 32'(err_free), 0);
        free_one(32);
        check("t4_dbl_count", 32'(free_count), 223);
        check("t4_dbl_err", 32'(err_free), 1);

        // 4c. Free of the tag being granted in the same cycle
        do_reset();
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_tag   = 8'd32;
        #1;
        check("t4_same_gnt", 32'(alloc_gnt), 1);
        tick();
        idle();
        check("t4_same_count", 32'(free_count), 223);
        check("t4_same_err", 32'(err_free), 1);
        check("t4_same_inv", 32'(inval_addr), 32);
        check("t4_same_next", 32'(alloc_tag), 33);

        // 5. Count 100: simultaneous alloc and free, then drain through the wrap
        do_reset();
        for (int k = 32; k < 156; k++) alloc_one($sformatf("t5_a%0d", k), k);
        check("t5_count100", 32'(free_count), 100);
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_tag   = 8'd7;
        #1;
        check("t5_sim_gnt", 32'(alloc_gnt), 1);
        check("t5_sim_tag", 32'(alloc_tag), 156);
        tick();
        idle();
        check("t5_sim_count", 32'(free_count), 100);
        check("t5_sim_err", 32'(err_free), 0);
        for (int k = 157; k < 256; k++) alloc_one($sformatf("t5_b%0d", k), k);
        alloc_one("t5_re7", 7);
        check("t5_empty", 32'(empty), 1);

        // 6. Tag 0 ignored; reset mid-stream
        free_one(0);
        check("t6_zero_count", 32'(free_count), 0);
        check("t6_zero_err", 32'(err_free), 0);
        free_one(40);
        check("t6_f40_count", 32'(free_count), 1);
        free_one(40);
        check("t6_dbl_err", 32'(err_free), 1);
        alloc_req = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check_reset_state("t6_async");
        tick();
        rst = 1'b0;
        idle();
        check_reset_state("t6_after");
        alloc_one("t6_a32", 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
